// File: rtl/alloc_arb_pkg.sv
// Shared defaults, tag type and round-robin helper for the allocator port arbiter.
package alloc_arb_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int REQ_WIDTH_DEF = 16;
  localparam int PTR_WIDTH_DEF = 16;
  localparam int TAG_DEPTH_DEF = 8;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] tag_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/alloc_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, gated by en_i.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end
endmodule

// File: rtl/alloc_port_arbiter.sv
// Shares one allocator between NUM_REQ requesters: RR malloc arbitration with an
// in-order tag FIFO for response routing, plus an independent RR free-pointer merge.
module alloc_port_arbiter import alloc_arb_pkg::*; #(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*REQ_WIDTH-1:0]   s_req_data,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  output logic [REQ_WIDTH-1:0]           m_req_data,
  output logic                           m_req_valid,
  input  logic                           m_req_ready,
  input  logic [PTR_WIDTH-1:0]           s_alloc_pointer,
  input  logic                           s_alloc_valid,
  output logic                           s_alloc_ready,
  output logic [PTR_WIDTH-1:0]           m_alloc_pointer,
  output logic [NUM_REQ-1:0]             m_alloc_valid,
  input  logic [NUM_REQ-1:0]             m_alloc_ready,
  input  logic [NUM_REQ*PTR_WIDTH-1:0]   s_free_pointer,
  input  logic [NUM_REQ-1:0]             s_free_valid,
  output logic [NUM_REQ-1:0]             s_free_ready,
  output logic [PTR_WIDTH-1:0]           m_free_pointer,
  output logic                           m_free_valid,
  input  logic                           m_free_ready,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err_orphan
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef logic [IW-1:0] idx_t;

  idx_t                 rr_req_q, rr_free_q, req_idx, free_idx, head;
  logic [NUM_REQ-1:0]   req_gnt, free_gnt;
  logic                 req_en, free_en, push, pop, empty, full;
  logic [REQ_WIDTH-1:0] req_sel, m_req_data_q;
  logic [PTR_WIDTH-1:0] free_sel, m_free_ptr_q;
  logic                 m_req_valid_q, m_free_valid_q, err_q;
  idx_t                 tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(TAG_DEPTH));
  assign head  = tag_mem_q[rd_q];

  assign s_alloc_ready   = !empty && m_alloc_ready[head];
  assign pop             = s_alloc_valid && s_alloc_ready;
  assign m_alloc_pointer = s_alloc_pointer;

  always_comb begin
    m_alloc_valid = '0;
    if (s_alloc_valid && !empty) m_alloc_valid[head] = 1'b1;
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a grant.
  assign req_en  = (!m_req_valid_q || m_req_ready) && (!full || pop);
  assign free_en = !m_free_valid_q || m_free_ready;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_req_arb (
    .req_i(s_req_valid), .ptr_i(rr_req_q), .en_i(req_en),
    .gnt_o(req_gnt), .gnt_idx_o(req_idx)
  );

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_free_arb (
    .req_i(s_free_valid), .ptr_i(rr_free_q), .en_i(free_en),
    .gnt_o(free_gnt), .gnt_idx_o(free_idx)
  );

  assign s_req_ready  = req_gnt;
  assign s_free_ready = free_gnt;
  assign push         = |req_gnt;

  always_comb begin
    req_sel  = '0;
    free_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_gnt[i])  req_sel  = s_req_data[i*REQ_WIDTH +: REQ_WIDTH];
      if (free_gnt[i]) free_sel = s_free_pointer[i*PTR_WIDTH +: PTR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_req_valid_q  <= 1'b0;
      m_req_data_q   <= '0;
      rr_req_q       <= '0;
      m_free_valid_q <= 1'b0;
      m_free_ptr_q   <= '0;
      rr_free_q      <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      if (push) begin
        m_req_valid_q <= 1'b1;
        m_req_data_q  <= req_sel;
        rr_req_q      <= IW'(rr_next(int'(req_idx), NUM_REQ));
        wr_q          <= (wr_q == PW'(TAG_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end else if (m_req_ready) begin
        m_req_valid_q <= 1'b0;
      end

      if (pop) rd_q <= (rd_q == PW'(TAG_DEPTH - 1)) ? '0 : rd_q + 1'b1;

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (|free_gnt) begin
        m_free_valid_q <= 1'b1;
        m_free_ptr_q   <= free_sel;
        rr_free_q      <= IW'(rr_next(int'(free_idx), NUM_REQ));
      end else if (m_free_ready) begin
        m_free_valid_q <= 1'b0;
      end

      if (s_alloc_valid && empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) tag_mem_q[wr_q] <= req_idx;
  end

  assign m_req_valid    = m_req_valid_q;
  assign m_req_data     = m_req_data_q;
  assign m_free_valid   = m_free_valid_q;
  assign m_free_pointer = m_free_ptr_q;
  assign outstanding    = cnt_q;
  assign err_orphan     = err_q;
endmodule
